ifetch_warp_scheduler: RTL and testbench
========================================

IFETCH_WARP_SCHEDULER -- requirements
Module: ifetch_warp_scheduler

Interface
REQ-001 Parameter NUM_WARPS, default NUM_WARPS_PER_SM (4): number of warps arbitrated.
REQ-002 Parameter WARP_IDX_WIDTH, default NUM_WARPS_PER_SM_WIDTH (2): warp index width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 warp_enable  in  NUM_WARPS  per-warp run enable.
REQ-006 ifs_fetch_valid  out  1  fetch request to L1I tag stage.
REQ-007 ifs_fetch_warp_idx  out  WARP_IDX_WIDTH  granted warp.
REQ-008 ifs_fetch_pc  out  32 (scalar_t)  fetch address of granted warp.
REQ-009 ifs_fetch_ready  in  1  tag stage accepts request this cycle.
REQ-010 ift_miss_valid  in  1  a previously issued fetch missed L1I.
REQ-011 ift_miss_warp_idx  in  WARP_IDX_WIDTH  warp that missed.
REQ-012 ift_miss_pc  in  32  PC that missed.
REQ-013 l2_fill_valid  in  1  L1I line fill completed.
REQ-014 l2_fill_addr  in  32  address of filled line.
REQ-015 rollback_en  in  1  redirect request (branch/exception).
REQ-016 rollback_warp_idx  in  WARP_IDX_WIDTH  warp redirected.
REQ-017 rollback_pc  in  32  new PC.
REQ-018 warp_waiting  out  NUM_WARPS  warp is in WAIT_FILL.

Function
REQ-019 Per warp: PC register and 2-state FSM READY/WAIT_FILL, plus recorded miss line address (bits [31:CACHE_LINE_BYTE_OFFSET_WIDTH]).
REQ-020 Eligible = warp_enable & READY & not targeted by rollback this cycle.
REQ-021 Round-robin grant among eligible warps, starting at index after last accepted warp, wrapping NUM_WARPS-1 -> 0.
REQ-022 ifs_fetch_valid = any eligible; warp_idx/pc combinational from registered state and rollback inputs; valid never depends on ifs_fetch_ready.
REQ-023 Request contents may change while ready low; only a valid&ready cycle is an issue.
REQ-024 On issue: granted PC <= PC+4 (mod 2^32 wrap), round-robin pointer <= granted index; no other update.
REQ-025 Miss: warp ift_miss_warp_idx -> WAIT_FILL, PC <= ift_miss_pc, line address recorded; takes effect next cycle.
REQ-026 Miss and issue to same warp in same cycle: miss wins (PC = ift_miss_pc).
REQ-027 Fill: every WAIT_FILL warp whose recorded line equals l2_fill_addr line -> READY next cycle; PC unchanged.
REQ-028 Fill matching the line of a same-cycle miss: warp stays READY (no lost wakeup).
REQ-029 Rollback: warp PC <= rollback_pc, state -> READY; overrides miss, fill and issue for that warp in same cycle.
REQ-030 warp_enable low: warp masked from arbitration only; PC and FSM state retained.
REQ-031 No eligible warp: ifs_fetch_valid=0, pointer unchanged.

Reset
REQ-032 On reset: all PCs = RESET_PC, all warps READY, pointer = NUM_WARPS-1 (first grant warp 0), recorded line addresses 0.
REQ-033 Reset outputs: ifs_fetch_valid follows warp_enable eligibility (0 if warp_enable=0), warp_waiting=0.
REQ-034 Reset mid-miss/mid-fill discards all pending waits; inputs ignored during reset cycle.

Structure
REQ-035 NUM_WARPS_PER_SM, NUM_WARPS_PER_SM_WIDTH, RESET_PC, scalar_t, CACHE_LINE_BYTE_OFFSET_WIDTH come from shared package defines; add warp_idx_t there.
REQ-036 One sub-module: rr_arbiter (parameterized round-robin request/grant with update-on-accept).

Verification
REQ-037 Reset, enable=4'b1111, ready=1 for 4 cycles -> grants 0,1,2,3, each pc=0x0; 5th cycle warp 0 pc=0x4.
REQ-038 Miss warp 1 pc=0x1040 -> warp_waiting=4'b0010, warp 1 skipped; fill addr 0x1000 -> ready next cycle, next warp 1 fetch pc=0x1040.
REQ-039 Warps 1,2 miss in line 0x2000 (pcs 0x2004, 0x2038), warp 3 in 0x3000; fill 0x2010 -> only warps 1,2 wake.
REQ-040 Rollback warp 2 pc=0x800 same cycle as miss warp 2 -> warp 2 READY, next fetch pc=0x800.
REQ-041 ready=0 for 5 cycles -> PCs and pointer unchanged; then ready=1 resumes at same warp.
REQ-042 PC=0xFFFFFFFC issued -> PC wraps to 0x0; reset asserted while warp 0 waiting -> waiting cleared, pc=RESET_PC.

Source files
------------

// File: rtl/ifetch_warp_scheduler_pkg.sv
// Shared fetch-side definitions: machine word, warp index, cache line geometry
// and the per-warp fetch state.
package ifetch_warp_scheduler_pkg;

  localparam int NUM_WARPS_PER_SM = 4;
  localparam int NUM_WARPS_PER_SM_WIDTH = 2;
  localparam int CACHE_LINE_BYTE_OFFSET_WIDTH = 7;
  localparam int LINE_ADDR_WIDTH = 32 - CACHE_LINE_BYTE_OFFSET_WIDTH;

  typedef logic [31:0] scalar_t;
  typedef logic [NUM_WARPS_PER_SM_WIDTH-1:0] warp_idx_t;
  typedef logic [LINE_ADDR_WIDTH-1:0] line_addr_t;

  localparam scalar_t RESET_PC = 32'h0000_0000;

  typedef enum logic {
    WARP_READY     = 1'b0,
    WARP_WAIT_FILL = 1'b1
  } warp_state_t;

  function automatic line_addr_t line_of(input scalar_t addr);
    return addr[31:CACHE_LINE_BYTE_OFFSET_WIDTH];
  endfunction

endpackage

// File: rtl/ifetch_warp_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the entry after the last accepted grant;
// the pointer only moves when the grant is accepted downstream.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         accept,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  logic [W-1:0] ptr_reg;

  always_comb begin
    int idx;
    idx = 0;
    grant_valid = 1'b0;
    grant_idx = ptr_reg;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr_reg) + off) % N;
      if (!grant_valid && request[idx]) begin
        grant_valid = 1'b1;
        grant_idx = W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= W'(N - 1);
    end else if (accept && grant_valid) begin
      ptr_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/ifetch_warp_scheduler.sv
// Instruction-fetch warp scheduler: per-warp PC and READY/WAIT_FILL tracking,
// round-robin issue of fetch requests to the L1I tag stage.
module ifetch_warp_scheduler
  import ifetch_warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = NUM_WARPS_PER_SM,
  parameter int WARP_IDX_WIDTH = NUM_WARPS_PER_SM_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_WARPS-1:0]      warp_enable,
  output logic                      ifs_fetch_valid,
  output logic [WARP_IDX_WIDTH-1:0] ifs_fetch_warp_idx,
  output scalar_t                   ifs_fetch_pc,
  input  logic                      ifs_fetch_ready,
  input  logic                      ift_miss_valid,
  input  logic [WARP_IDX_WIDTH-1:0] ift_miss_warp_idx,
  input  scalar_t                   ift_miss_pc,
  input  logic                      l2_fill_valid,
  input  scalar_t                   l2_fill_addr,
  input  logic                      rollback_en,
  input  logic [WARP_IDX_WIDTH-1:0] rollback_warp_idx,
  input  scalar_t                   rollback_pc,
  output logic [NUM_WARPS-1:0]      warp_waiting
);

  logic [NUM_WARPS-1:0]      eligible;
  scalar_t                   pc_all [NUM_WARPS];
  logic                      grant_valid;
  logic [WARP_IDX_WIDTH-1:0] grant_idx;
  logic                      issue;
  line_addr_t                fill_line;
  line_addr_t                miss_line;

  assign issue     = grant_valid && ifs_fetch_ready;
  assign fill_line = line_of(l2_fill_addr);
  assign miss_line = line_of(ift_miss_pc);

  rr_arbiter #(
    .N (NUM_WARPS),
    .W (WARP_IDX_WIDTH)
  ) u_arbiter (
    .clk         (clk),
    .reset       (reset),
    .request     (eligible),
    .accept      (ifs_fetch_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign ifs_fetch_valid    = grant_valid;
  assign ifs_fetch_warp_idx = grant_idx;
  assign ifs_fetch_pc       = pc_all[grant_idx];

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    warp_state_t state_reg, state_next;
    scalar_t     pc_reg, pc_next;
    line_addr_t  line_reg, line_next;
    logic        rb_hit, miss_hit, issue_hit;

    assign rb_hit    = rollback_en && (rollback_warp_idx == WARP_IDX_WIDTH'(gi));
    assign miss_hit  = ift_miss_valid && (ift_miss_warp_idx == WARP_IDX_WIDTH'(gi));
    assign issue_hit = issue && (grant_idx == WARP_IDX_WIDTH'(gi));

    // Priority per warp: rollback, then miss, then issue/fill.
    always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      line_next  = line_reg;
      if (rb_hit) begin
        pc_next    = rollback_pc;
        state_next = WARP_READY;
      end else if (miss_hit) begin
        pc_next    = ift_miss_pc;
        line_next  = miss_line;
        // A fill of the very line that just missed must not be lost.
        state_next = (l2_fill_valid && (fill_line == miss_line)) ? WARP_READY : WARP_WAIT_FILL;
      end else begin
        if (issue_hit) begin
          pc_next = pc_reg + 32'd4;
        end
        if (state_reg == WARP_WAIT_FILL && l2_fill_valid && fill_line == line_reg) begin
          state_next = WARP_READY;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= WARP_READY;
        pc_reg    <= RESET_PC;
        line_reg  <= '0;
      end else begin
        state_reg <= state_next;
        pc_reg    <= pc_next;
        line_reg  <= line_next;
      end
    end

    assign eligible[gi]     = warp_enable[gi] && (state_reg == WARP_READY) && !rb_hit;
    assign warp_waiting[gi] = (state_reg == WARP_WAIT_FILL);
    assign pc_all[gi]       = pc_reg;
  end

endmodule

// File: tb/tb_ifetch_warp_scheduler.sv
// Directed and random checks of the fetch warp scheduler against a
// behavioural per-warp model.
module tb_ifetch_warp_scheduler;
  import ifetch_warp_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  warp_enable = 4'b1111;
  logic        ifs_fetch_valid;
  logic [1:0]  ifs_fetch_warp_idx;
  logic [31:0] ifs_fetch_pc;
  logic        ifs_fetch_ready = 1'b1;
  logic        ift_miss_valid = 1'b0;
  logic [1:0]  ift_miss_warp_idx = '0;
  logic [31:0] ift_miss_pc = '0;
  logic        l2_fill_valid = 1'b0;
  logic [31:0] l2_fill_addr = '0;
  logic        rollback_en = 1'b0;
  logic [1:0]  rollback_warp_idx = '0;
  logic [31:0] rollback_pc = '0;
  logic [3:0]  warp_waiting;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  logic [31:0] m_pc [4];
  bit          m_wait [4];
  logic [31:0] m_line [4];
  int          m_ptr;

  // Observations and model predictions of the last tick
  logic        obs_valid;
  logic [1:0]  obs_idx;
  logic [31:0] obs_pc;
  logic [3:0]  obs_waiting;
  int          last_e_idx;
  bit          skip_chk;

  always #5 clk = ~clk;

  ifetch_warp_scheduler dut (
    .clk                (clk),
    .reset              (reset),
    .warp_enable        (warp_enable),
    .ifs_fetch_valid    (ifs_fetch_valid),
    .ifs_fetch_warp_idx (ifs_fetch_warp_idx),
    .ifs_fetch_pc       (ifs_fetch_pc),
    .ifs_fetch_ready    (ifs_fetch_ready),
    .ift_miss_valid     (ift_miss_valid),
    .ift_miss_warp_idx  (ift_miss_warp_idx),
    .ift_miss_pc        (ift_miss_pc),
    .l2_fill_valid      (l2_fill_valid),
    .l2_fill_addr       (l2_fill_addr),
    .rollback_en        (rollback_en),
    .rollback_warp_idx  (rollback_warp_idx),
    .rollback_pc        (rollback_pc),
    .warp_waiting       (warp_waiting)
  );

  function automatic logic [31:0] line_id(input logic [31:0] a);
    return a >> CACHE_LINE_BYTE_OFFSET_WIDTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: predict outputs from the model, compare, then advance the model.
  task automatic tick();
    bit         e_valid;
    int         e_idx;
    int         w;
    logic [3:0] e_wait;
    e_valid = 0;
    e_idx = 0;
    e_wait = '0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      w = (m_ptr + k) % 4;
      if (!e_valid && warp_enable[w] && !m_wait[w] && !(rollback_en && int'(rollback_warp_idx) == w)) begin
        e_valid = 1;
        e_idx = w;
      end
    end
    for (int i = 0; i < 4; i++) e_wait[i] = m_wait[i];
    last_e_idx = e_idx;
    obs_valid = ifs_fetch_valid;
    obs_idx = ifs_fetch_warp_idx;
    obs_pc = ifs_fetch_pc;
    obs_waiting = warp_waiting;
    if (!skip_chk) begin
      check("valid", {31'd0, obs_valid}, {31'd0, e_valid});
      if (e_valid) begin
        check("warp_idx", {30'd0, obs_idx}, e_idx);
        check("pc", obs_pc, m_pc[e_idx]);
      end
      check("waiting", {28'd0, obs_waiting}, {28'd0, e_wait});
    end
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_pc[i] = RESET_PC;
        m_wait[i] = 0;
        m_line[i] = 0;
      end
      m_ptr = 3;
    end else begin
      if (e_valid && ifs_fetch_ready) begin
        m_pc[e_idx] = m_pc[e_idx] + 32'd4;
        m_ptr = e_idx;
      end
      if (l2_fill_valid)
        for (int i = 0; i < 4; i++)
          if (m_wait[i] && m_line[i] == line_id(l2_fill_addr)) m_wait[i] = 0;
      if (ift_miss_valid) begin
        m_pc[ift_miss_warp_idx] = ift_miss_pc;
        m_line[ift_miss_warp_idx] = line_id(ift_miss_pc);
        m_wait[ift_miss_warp_idx] = !(l2_fill_valid && line_id(l2_fill_addr) == line_id(ift_miss_pc));
      end
      if (rollback_en) begin
        m_pc[rollback_warp_idx] = rollback_pc;
        m_wait[rollback_warp_idx] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    ift_miss_valid = 0;
    l2_fill_valid = 0;
    rollback_en = 0;
  endtask

  initial begin
    bit found;
    int held;
    logic [31:0] base [3];
    base[0] = 32'h1000;
    base[1] = 32'h2000;
    base[2] = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      m_pc[i] = RESET_PC;
      m_wait[i] = 0;
      m_line[i] = 0;
    end
    m_ptr = 3;

    // Reset; the first cycle's outputs precede any reset edge
    skip_chk = 1;
    tick();
    skip_chk = 0;
    tick();
    check("reset_waiting", {28'd0, obs_waiting}, 32'd0);
    check("reset_idx", {30'd0, obs_idx}, 32'd0);
    reset = 0;

    // Boot: grants 0..3 at RESET_PC, then warp 0 at +4
    for (int i = 0; i < 4; i++) begin
      tick();
      check("boot_idx", {30'd0, obs_idx}, i);
      check("boot_pc", obs_pc, 32'h0);
    end
    tick();
    check("wrap_idx", {30'd0, obs_idx}, 32'd0);
    check("wrap_pc", obs_pc, 32'h4);

    // Miss on warp 1, then fill of its line
    ift_miss_valid = 1; ift_miss_warp_idx = 1; ift_miss_pc = 32'h1040;
    tick();
    clear_pulses();
    tick();
    check("miss_waiting", {28'd0, obs_waiting}, 32'b0010);
    check("miss_skip_idx", {30'd0, obs_idx}, 32'd2);
    tick();
    l2_fill_valid = 1; l2_fill_addr = 32'h1000;
    tick();
    clear_pulses();
    found = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!found && obs_valid && obs_idx == 2'd1) begin
        found = 1;
        check("refetch_pc", obs_pc, 32'h1040);
      end
    end
    check("refetch_found", {31'd0, found}, 32'd1);

    // Three misses in two lines, fill wakes only the shared line
    ifs_fetch_ready = 0;
    ift_miss_valid = 1; ift_miss_warp_idx = 1; ift_miss_pc = 32'h2004;
    tick();
    ift_miss_warp_idx = 2; ift_miss_pc = 32'h2038;
    tick();
    ift_miss_warp_idx = 3; ift_miss_pc = 32'h3004;
    tick();
    clear_pulses();
    check("three_wait", {28'd0, warp_waiting}, 32'b1110);
    l2_fill_valid = 1; l2_fill_addr = 32'h2010;
    tick();
    clear_pulses();
    tick();
    check("partial_wake", {28'd0, obs_waiting}, 32'b1000);

    // Rollback beats a same-cycle miss
    rollback_en = 1; rollback_warp_idx = 2; rollback_pc = 32'h800;
    ift_miss_valid = 1; ift_miss_warp_idx = 2; ift_miss_pc = 32'h9000;
    tick();
    clear_pulses();
    warp_enable = 4'b0100;
    ifs_fetch_ready = 1;
    tick();
    check("rb_waiting", {28'd0, obs_waiting}, 32'b1000);
    check("rb_idx", {30'd0, obs_idx}, 32'd2);
    check("rb_pc", obs_pc, 32'h800);
    l2_fill_valid = 1; l2_fill_addr = 32'h3000;
    tick();
    clear_pulses();

    // Back-pressure holds the request and the pointer
    warp_enable = 4'b1111;
    ifs_fetch_ready = 0;
    tick();
    held = last_e_idx;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_idx", {30'd0, obs_idx}, held);
    end
    ifs_fetch_ready = 1;
    tick();
    check("resume_idx", {30'd0, obs_idx}, held);

    // PC wrap at the top of the address space
    warp_enable = 4'b0001;
    rollback_en = 1; rollback_warp_idx = 0; rollback_pc = 32'hFFFF_FFFC;
    tick();
    check("rb_cycle_valid", {31'd0, obs_valid}, 32'd0);
    clear_pulses();
    tick();
    check("top_pc", obs_pc, 32'hFFFF_FFFC);
    tick();
    check("wrapped_pc", obs_pc, 32'h0);

    // Reset while warp 0 waits on a fill
    ifs_fetch_ready = 0;
    ift_miss_valid = 1; ift_miss_warp_idx = 0; ift_miss_pc = 32'h5000;
    tick();
    clear_pulses();
    tick();
    check("pre_reset_wait", {28'd0, obs_waiting}, 32'b0001);
    reset = 1;
    tick();
    reset = 0;
    tick();
    check("post_reset_wait", {28'd0, obs_waiting}, 32'd0);
    check("post_reset_pc", obs_pc, RESET_PC);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      warp_enable = 4'($urandom_range(0, 15));
      ifs_fetch_ready = ($urandom_range(0, 9) < 7);
      ift_miss_valid = ($urandom_range(0, 9) < 3);
      ift_miss_warp_idx = 2'($urandom_range(0, 3));
      ift_miss_pc = base[$urandom_range(0, 2)] + 32'($urandom_range(0, 31) * 4);
      l2_fill_valid = ($urandom_range(0, 3) == 0);
      l2_fill_addr = base[$urandom_range(0, 2)] + 32'($urandom_range(0, 127));
      rollback_en = ($urandom_range(0, 9) == 0);
      rollback_warp_idx = 2'($urandom_range(0, 3));
      rollback_pc = 32'($urandom_range(0, 1023) * 4);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
